// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator (640x480@60 defaults).
// Runtime-programmable timing is enabled by defining VGA_TIMING_PROG_EN.
package vga_timing_pkg;

    localparam int unsigned DEF_CW       = 11;
    localparam int unsigned CFG_W        = DEF_CW;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam bit          DEF_HS_POL   = 1'b0;
    localparam bit          DEF_VS_POL   = 1'b0;

    localparam logic [2:0] CFG_H_ACTIVE = 3'd0;
    localparam logic [2:0] CFG_H_FP     = 3'd1;
    localparam logic [2:0] CFG_H_SYNC   = 3'd2;
    localparam logic [2:0] CFG_H_BP     = 3'd3;
    localparam logic [2:0] CFG_V_ACTIVE = 3'd4;
    localparam logic [2:0] CFG_V_FP     = 3'd5;
    localparam logic [2:0] CFG_V_SYNC   = 3'd6;
    localparam logic [2:0] CFG_V_BP     = 3'd7;

    typedef struct packed {
        logic [CFG_W-1:0] h_active;
        logic [CFG_W-1:0] h_fp;
        logic [CFG_W-1:0] h_sync;
        logic [CFG_W-1:0] h_bp;
        logic [CFG_W-1:0] v_active;
        logic [CFG_W-1:0] v_fp;
        logic [CFG_W-1:0] v_sync;
        logic [CFG_W-1:0] v_bp;
    } vga_timing_t;

    // Returns cur with the field selected by addr replaced by data.
    function automatic vga_timing_t cfg_write(input vga_timing_t cur, input logic [2:0] addr,
                                              input logic [CFG_W-1:0] data);
        vga_timing_t nxt;
        nxt = cur;
        case (addr)
            CFG_H_ACTIVE: nxt.h_active = data;
            CFG_H_FP:     nxt.h_fp     = data;
            CFG_H_SYNC:   nxt.h_sync   = data;
            CFG_H_BP:     nxt.h_bp     = data;
            CFG_V_ACTIVE: nxt.v_active = data;
            CFG_V_FP:     nxt.v_fp     = data;
            CFG_V_SYNC:   nxt.v_sync   = data;
            CFG_V_BP:     nxt.v_bp     = data;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus between the timing generator (master) and the pixel pipeline (slave).
// Configuration signals exist only when VGA_TIMING_PROG_EN is defined.
interface vga_timing_gen_if #(
    parameter int unsigned CW = 11
);
    logic          pix_en;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          blank;
    logic          de;
    logic          line_start;
    logic          frame_start;
`ifdef VGA_TIMING_PROG_EN
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_busy;

    modport master (
        output pix_en, hcount, vcount, hsync, vsync, blank, de, line_start, frame_start,
        input  cfg_we, cfg_addr, cfg_data, cfg_commit,
        output cfg_busy
    );
    modport slave (
        input  pix_en, hcount, vcount, hsync, vsync, blank, de, line_start, frame_start,
        output cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  cfg_busy
    );
`else
    modport master (
        output pix_en, hcount, vcount, hsync, vsync, blank, de, line_start, frame_start
    );
    modport slave (
        input  pix_en, hcount, vcount, hsync, vsync, blank, de, line_start, frame_start
    );
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, plus sync and active decode of the next count.
module vga_axis_counter #(
    parameter int unsigned CW  = 11,
    parameter bit          POL = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_adv,
    input  logic [CW-1:0] i_active,
    input  logic [CW-1:0] i_fp,
    input  logic [CW-1:0] i_sync,
    input  logic [CW-1:0] i_bp,
    output logic [CW-1:0] o_count,
    output logic          o_sync,
    output logic          o_last_c,
    output logic          o_active_nx_c
);

    logic [CW-1:0] w_sync_start;
    logic [CW-1:0] w_sync_end;
    logic [CW-1:0] w_total;
    logic [CW-1:0] w_next;
    logic [CW-1:0] r_count;
    logic          r_sync;

    assign w_sync_start = i_active + i_fp;
    assign w_sync_end   = w_sync_start + i_sync;
    assign w_total      = w_sync_end + i_bp;
    assign o_last_c     = (r_count == w_total - CW'(1));

    always_comb begin
        w_next = r_count;
        if (i_adv) begin
            w_next = o_last_c ? '0 : r_count + CW'(1);
        end
    end

    assign o_active_nx_c = (w_next < i_active);

    // Sync is decoded from the next count so it lines up with the count it describes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_sync  <= ~POL;
        end else begin
            r_count <= w_next;
            r_sync  <= ((w_next >= w_sync_start) && (w_next < w_sync_end)) ? POL : ~POL;
        end
    end

    assign o_count = r_count;
    assign o_sync  = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel enable divider, H/V counters, sync/blank/strobes.
// Define VGA_TIMING_PROG_EN for runtime-programmable timing applied at frame boundaries.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = DEF_HS_POL,
    parameter bit          VS_POL   = DEF_VS_POL,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    vga_timing_gen_if.master io_bus
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam vga_timing_t P_CFG = '{
        h_active: CFG_W'(H_ACTIVE), h_fp: CFG_W'(H_FP), h_sync: CFG_W'(H_SYNC), h_bp: CFG_W'(H_BP),
        v_active: CFG_W'(V_ACTIVE), v_fp: CFG_W'(V_FP), v_sync: CFG_W'(V_SYNC), v_bp: CFG_W'(V_BP)
    };

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    logic             r_blank;
    logic             r_de;
    logic             r_line_start;
    logic             r_frame_start;
    logic             w_div_last;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_h_act_nx;
    logic             w_v_act_nx;
    logic             w_line_wrap;
    logic             w_frame_wrap;
    logic [CW-1:0]    w_hcount;
    logic [CW-1:0]    w_vcount;
    logic             w_hsync;
    logic             w_vsync;
    vga_timing_t      w_cfg;

    assign w_div_last   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_line_wrap  = r_pix_en & w_h_last;
    assign w_frame_wrap = w_line_wrap & w_v_last;

`ifdef VGA_TIMING_PROG_EN
    vga_timing_t r_stage;
    vga_timing_t r_act_cfg;
    logic        r_busy;

    // Staged fields move to the active set only at the frame wrap, so a frame never mixes timings.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stage   <= P_CFG;
            r_act_cfg <= P_CFG;
            r_busy    <= 1'b0;
        end else begin
            if (io_bus.cfg_we) begin
                r_stage <= cfg_write(r_stage, io_bus.cfg_addr, CFG_W'(io_bus.cfg_data));
            end
            if (w_frame_wrap && r_busy) begin
                r_act_cfg <= r_stage;
                r_busy    <= 1'b0;
            end else if (io_bus.cfg_commit) begin
                r_busy <= 1'b1;
            end
        end
    end

    assign w_cfg           = r_act_cfg;
    assign io_bus.cfg_busy = r_busy;
`else
    assign w_cfg = P_CFG;
`endif

    vga_axis_counter #(.CW(CW), .POL(HS_POL)) u_h (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_adv         (r_pix_en),
        .i_active      (CW'(w_cfg.h_active)),
        .i_fp          (CW'(w_cfg.h_fp)),
        .i_sync        (CW'(w_cfg.h_sync)),
        .i_bp          (CW'(w_cfg.h_bp)),
        .o_count       (w_hcount),
        .o_sync        (w_hsync),
        .o_last_c      (w_h_last),
        .o_active_nx_c (w_h_act_nx)
    );

    vga_axis_counter #(.CW(CW), .POL(VS_POL)) u_v (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_adv         (w_line_wrap),
        .i_active      (CW'(w_cfg.v_active)),
        .i_fp          (CW'(w_cfg.v_fp)),
        .i_sync        (CW'(w_cfg.v_sync)),
        .i_bp          (CW'(w_cfg.v_bp)),
        .o_count       (w_vcount),
        .o_sync        (w_vsync),
        .o_last_c      (w_v_last),
        .o_active_nx_c (w_v_act_nx)
    );

    // Divider, pixel enable and the registered blank/strobe outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div         <= '0;
            r_pix_en      <= 1'b0;
            r_blank       <= 1'b0;
            r_de          <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_div_last ? '0 : r_div + DIV_W'(1);
            r_pix_en      <= w_div_last;
            r_blank       <= ~(w_h_act_nx & w_v_act_nx);
            r_de          <= w_h_act_nx & w_v_act_nx;
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

    assign io_bus.pix_en      = r_pix_en;
    assign io_bus.hcount      = w_hcount;
    assign io_bus.vcount      = w_vcount;
    assign io_bus.hsync       = w_hsync;
    assign io_bus.vsync       = w_vsync;
    assign io_bus.blank       = r_blank;
    assign io_bus.de          = r_de;
    assign io_bus.line_start  = r_line_start;
    assign io_bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default, fast-divider and small-raster instances.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int unsigned CW = 11;

    logic clk       = 1'b0;
    logic rst_def   = 1'b0;
    logic rst_fast  = 1'b0;
    logic rst_small = 1'b0;
    int   errors    = 0;
    int   checks    = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(CW)) if_def ();
    vga_timing_gen_if #(.CW(CW)) if_fast ();
    vga_timing_gen_if #(.CW(CW)) if_small ();

    vga_timing_gen #(.CW(CW)) u_def (.i_clk(clk), .i_rst_n(rst_def), .io_bus(if_def));

    vga_timing_gen #(.CW(CW), .CLK_DIV(1), .HS_POL(1'b1), .H_FP(0)) u_fast (
        .i_clk(clk), .i_rst_n(rst_fast), .io_bus(if_fast));

    // H_TOTAL = 15, V_TOTAL = 8, CLK_DIV = 2 -> 240 clks per frame
    vga_timing_gen #(.CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) u_small (
        .i_clk(clk), .i_rst_n(rst_small), .io_bus(if_small));

    task automatic test_reset();
        logic [2*CW+6:0] got;
        rst_def = 1'b0; rst_fast = 1'b0; rst_small = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        got = {if_def.pix_en, if_def.hcount, if_def.vcount, if_def.hsync, if_def.vsync,
               if_def.blank, if_def.de, if_def.line_start, if_def.frame_start};
        checks++;
        if (got !== {1'b0, CW'(0), CW'(0), 6'b110100}) begin
            errors++;
            $display("FAIL reset_def got=%h exp=%h", got, {1'b0, CW'(0), CW'(0), 6'b110100});
        end
        got = {if_fast.pix_en, if_fast.hcount, if_fast.vcount, if_fast.hsync, if_fast.vsync,
               if_fast.blank, if_fast.de, if_fast.line_start, if_fast.frame_start};
        checks++;
        if (got !== {1'b0, CW'(0), CW'(0), 6'b010100}) begin
            errors++;
            $display("FAIL reset_fast got=%h exp=%h", got, {1'b0, CW'(0), CW'(0), 6'b010100});
        end
`ifdef VGA_TIMING_PROG_EN
        checks++;
        if (if_small.cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", if_small.cfg_busy);
        end
`endif
    endtask

    // First line of the default 800x525 raster, clk by clk.
    task automatic test_default_line();
        int   adv, eh, ev;
        logic e_pix, e_hs, e_de, e_ls;
        bit   bad_p = 1'b0, bad_c = 1'b0, bad_hs = 1'b0, bad_de = 1'b0, bad_ls = 1'b0, bad_fs = 1'b0;
        rst_def = 1'b1;
        for (int k = 1; k <= 1602; k++) begin
            @(posedge clk);
            #1;
            adv   = (k - 1) / 2;
            eh    = adv % 800;
            ev    = adv / 800;
            e_pix = (k % 2 == 0);
            e_hs  = !((eh >= 656) && (eh < 752));
            e_de  = (eh < 640) && (ev < 480);
            e_ls  = (k % 2 == 1) && (k >= 3) && (eh == 0);
            if (!bad_p) begin
                checks++;
                if (if_def.pix_en !== e_pix) begin
                    errors++; bad_p = 1'b1;
                    $display("FAIL def_pix_en clk=%0d got=%b exp=%b", k, if_def.pix_en, e_pix);
                end
            end
            if (!bad_c) begin
                checks++;
                if (if_def.hcount !== CW'(eh) || if_def.vcount !== CW'(ev)) begin
                    errors++; bad_c = 1'b1;
                    $display("FAIL def_count clk=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             k, if_def.hcount, if_def.vcount, eh, ev);
                end
            end
            if (!bad_hs) begin
                checks++;
                if (if_def.hsync !== e_hs) begin
                    errors++; bad_hs = 1'b1;
                    $display("FAIL def_hsync h=%0d got=%b exp=%b", eh, if_def.hsync, e_hs);
                end
            end
            if (!bad_de) begin
                checks++;
                if (if_def.de !== e_de || if_def.blank !== !e_de) begin
                    errors++; bad_de = 1'b1;
                    $display("FAIL def_de h=%0d got de=%b blank=%b exp de=%b", eh, if_def.de,
                             if_def.blank, e_de);
                end
            end
            if (!bad_ls) begin
                checks++;
                if (if_def.line_start !== e_ls) begin
                    errors++; bad_ls = 1'b1;
                    $display("FAIL def_line_start clk=%0d got=%b exp=%b", k, if_def.line_start, e_ls);
                end
            end
            if (!bad_fs) begin
                checks++;
                if (if_def.frame_start !== 1'b0) begin
                    errors++; bad_fs = 1'b1;
                    $display("FAIL def_frame_start clk=%0d got=%b exp=0", k, if_def.frame_start);
                end
            end
        end
    endtask

    // CLK_DIV=1, active-high hsync, no front porch (H_TOTAL = 784).
    task automatic test_fast();
        int   eh;
        logic e_hs, e_ls;
        bit   bad_p = 1'b0, bad_c = 1'b0, bad_hs = 1'b0, bad_ls = 1'b0;
        rst_fast = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            @(posedge clk);
            #1;
            eh   = (k - 1) % 784;
            e_hs = (eh >= 640) && (eh < 736);
            e_ls = (k > 1) && (eh == 0);
            if (!bad_p) begin
                checks++;
                if (if_fast.pix_en !== 1'b1) begin
                    errors++; bad_p = 1'b1;
                    $display("FAIL fast_pix_en clk=%0d got=%b exp=1", k, if_fast.pix_en);
                end
            end
            if (!bad_c) begin
                checks++;
                if (if_fast.hcount !== CW'(eh)) begin
                    errors++; bad_c = 1'b1;
                    $display("FAIL fast_hcount clk=%0d got=%0d exp=%0d", k, if_fast.hcount, eh);
                end
            end
            if (!bad_hs) begin
                checks++;
                if (if_fast.hsync !== e_hs) begin
                    errors++; bad_hs = 1'b1;
                    $display("FAIL fast_hsync h=%0d got=%b exp=%b", eh, if_fast.hsync, e_hs);
                end
            end
            if (!bad_ls) begin
                checks++;
                if (if_fast.line_start !== e_ls) begin
                    errors++; bad_ls = 1'b1;
                    $display("FAIL fast_line_start clk=%0d got=%b exp=%b", k, if_fast.line_start, e_ls);
                end
            end
        end
    endtask

    // Two full frames of the small raster: vsync, blank, frame_start position and spacing.
    task automatic test_small_frame();
        int   adv, eh, ev, n_fs, fs0, fs1;
        logic e_hs, e_vs, e_bl, e_fs;
        bit   bad_c = 1'b0, bad_s = 1'b0, bad_bl = 1'b0, bad_fs = 1'b0;
        n_fs = 0; fs0 = 0; fs1 = 0;
        rst_small = 1'b1;
        for (int k = 1; k <= 490; k++) begin
            @(posedge clk);
            #1;
            adv  = (k - 1) / 2;
            eh   = adv % 15;
            ev   = (adv / 15) % 8;
            e_hs = !((eh >= 10) && (eh < 13));
            e_vs = !((ev >= 5) && (ev < 7));
            e_bl = (eh >= 8) || (ev >= 4);
            e_fs = (k % 2 == 1) && (k >= 3) && (eh == 0) && (ev == 0);
            if (if_small.frame_start === 1'b1) begin
                if (n_fs == 0) fs0 = k;
                else if (n_fs == 1) fs1 = k;
                n_fs++;
            end
            if (!bad_c) begin
                checks++;
                if (if_small.hcount !== CW'(eh) || if_small.vcount !== CW'(ev)) begin
                    errors++; bad_c = 1'b1;
                    $display("FAIL small_count clk=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             k, if_small.hcount, if_small.vcount, eh, ev);
                end
            end
            if (!bad_s) begin
                checks++;
                if (if_small.hsync !== e_hs || if_small.vsync !== e_vs) begin
                    errors++; bad_s = 1'b1;
                    $display("FAIL small_sync (%0d,%0d) got hs=%b vs=%b exp hs=%b vs=%b",
                             eh, ev, if_small.hsync, if_small.vsync, e_hs, e_vs);
                end
            end
            if (!bad_bl) begin
                checks++;
                if (if_small.blank !== e_bl || if_small.de !== !e_bl) begin
                    errors++; bad_bl = 1'b1;
                    $display("FAIL small_blank (%0d,%0d) got=%b exp=%b", eh, ev, if_small.blank, e_bl);
                end
            end
            if (!bad_fs) begin
                checks++;
                if (if_small.frame_start !== e_fs) begin
                    errors++; bad_fs = 1'b1;
                    $display("FAIL small_frame_start clk=%0d got=%b exp=%b", k, if_small.frame_start, e_fs);
                end
            end
        end
        checks++;
        if (fs0 != 241) begin
            errors++;
            $display("FAIL first_frame_start got clk=%0d exp clk=241", fs0);
        end
        checks++;
        if (n_fs != 2 || (fs1 - fs0) != 240) begin
            errors++;
            $display("FAIL frame_spacing got count=%0d gap=%0d exp count=2 gap=240", n_fs, fs1 - fs0);
        end
    endtask

`ifdef VGA_TIMING_PROG_EN
    // Shrink H_ACTIVE to 4 mid-frame; new line period 11 pixels * 2 clks from the next frame.
    task automatic test_prog();
        int n;
        bit bad_b = 1'b0;
        n = 0;
        while (if_small.vcount !== CW'(2) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (if_small.vcount !== CW'(2)) begin
            errors++;
            $display("FAIL prog_wait_v2 got=%0d exp=2", if_small.vcount);
        end
        if_small.cfg_we = 1'b1; if_small.cfg_addr = CFG_H_ACTIVE;
        if_small.cfg_data = CW'(4); if_small.cfg_commit = 1'b1;
        @(posedge clk); #1;
        if_small.cfg_we = 1'b0; if_small.cfg_commit = 1'b0;
        checks++;
        if (if_small.cfg_busy !== 1'b1) begin
            errors++;
            $display("FAIL prog_busy_rise got=%b exp=1", if_small.cfg_busy);
        end
        repeat (5) @(posedge clk);
        #1 if_small.cfg_commit = 1'b1;
        @(posedge clk); #1;
        if_small.cfg_commit = 1'b0;
        n = 0;
        while (if_small.frame_start !== 1'b1 && n < 400) begin
            if (!bad_b) begin
                checks++;
                if (if_small.cfg_busy !== 1'b1) begin
                    errors++; bad_b = 1'b1;
                    $display("FAIL prog_busy_hold got=%b exp=1", if_small.cfg_busy);
                end
            end
            @(posedge clk); #1; n++;
        end
        checks++;
        if (if_small.frame_start !== 1'b1 || if_small.cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL prog_wrap got fs=%b busy=%b exp fs=1 busy=0",
                     if_small.frame_start, if_small.cfg_busy);
        end
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (if_small.line_start !== 1'b1 && n < 100);
        checks++;
        if (n != 22) begin
            errors++;
            $display("FAIL prog_line_period got=%0d exp=22", n);
        end
        checks++;
        if (if_small.cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL prog_busy_extended got=%b exp=0", if_small.cfg_busy);
        end
    endtask
`endif

    // One-clk reset in mid-frame: everything, including config and pending commit, starts over.
    task automatic test_mid_reset();
        logic [2*CW+6:0] got;
        int n;
        n = 0;
        while (!(if_small.hcount === CW'(6) && if_small.vcount === CW'(3)) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (if_small.hcount !== CW'(6) || if_small.vcount !== CW'(3)) begin
            errors++;
            $display("FAIL mid_wait got=(%0d,%0d) exp=(6,3)", if_small.hcount, if_small.vcount);
        end
`ifdef VGA_TIMING_PROG_EN
        if_small.cfg_we = 1'b1; if_small.cfg_addr = CFG_H_ACTIVE;
        if_small.cfg_data = CW'(6); if_small.cfg_commit = 1'b1;
        @(posedge clk); #1;
        if_small.cfg_we = 1'b0; if_small.cfg_commit = 1'b0;
`endif
        rst_small = 1'b0;
        @(posedge clk); #1;
        got = {if_small.pix_en, if_small.hcount, if_small.vcount, if_small.hsync, if_small.vsync,
               if_small.blank, if_small.de, if_small.line_start, if_small.frame_start};
        checks++;
        if (got !== {1'b0, CW'(0), CW'(0), 6'b110100}) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", got, {1'b0, CW'(0), CW'(0), 6'b110100});
        end
`ifdef VGA_TIMING_PROG_EN
        checks++;
        if (if_small.cfg_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_busy got=%b exp=0", if_small.cfg_busy);
        end
`endif
        rst_small = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 2) begin
                checks++;
                if (if_small.pix_en !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_restart_pix_en got=%b exp=1", if_small.pix_en);
                end
            end
            if (k == 3) begin
                checks++;
                if (if_small.hcount !== CW'(1)) begin
                    errors++;
                    $display("FAIL mid_restart_hcount got=%0d exp=1", if_small.hcount);
                end
            end
        end
`ifdef VGA_TIMING_PROG_EN
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                if_small.cfg_commit = 1'b1;
                @(posedge clk); #1;
                if_small.cfg_commit = 1'b0;
            end
            n = 0;
            while (if_small.frame_start !== 1'b1 && n < 400) begin
                @(posedge clk); #1; n++;
            end
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (if_small.line_start !== 1'b1 && n < 100);
            checks++;
            if (n != 30) begin
                errors++;
                $display("FAIL mid_cfg_restored pass=%0d got period=%0d exp=30", pass, n);
            end
        end
`endif
    endtask

    initial begin
`ifdef VGA_TIMING_PROG_EN
        if_def.cfg_we   = 1'b0; if_def.cfg_addr   = '0; if_def.cfg_data   = '0; if_def.cfg_commit   = 1'b0;
        if_fast.cfg_we  = 1'b0; if_fast.cfg_addr  = '0; if_fast.cfg_data  = '0; if_fast.cfg_commit  = 1'b0;
        if_small.cfg_we = 1'b0; if_small.cfg_addr = '0; if_small.cfg_data = '0; if_small.cfg_commit = 1'b0;
`endif
        test_reset();
        test_default_line();
        test_fast();
        test_small_frame();
`ifdef VGA_TIMING_PROG_EN
        test_prog();
`endif
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
